// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : mem_port_arbiter
// Purpose : Shares a single memory-controller port between NUM_REQ core-side
//           requesters. Round-robin grant, one transaction in flight,
//           registered request issue and response forwarding, watchdog abort
//           when the memory never answers.
// Ports   : CLK, RST (async, active low)
//           r_rw_flag/r_addr/r_wdata/r_wmask  per-requester request (flat)
//           r_rdata/r_done/r_err/r_busy       per-requester response/status
//           m_rw_flag/m_addr/m_wdata/m_wmask  request towards memory port
//           m_rdata/m_busy/m_done             response from memory port
// Rev     : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 1023,
  parameter int TO_W    = 10
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [2*NUM_REQ-1:0]    r_rw_flag,
  input  logic [32*NUM_REQ-1:0]   r_addr,
  input  logic [32*NUM_REQ-1:0]   r_wdata,
  input  logic [4*NUM_REQ-1:0]    r_wmask,
  output logic [31:0]             r_rdata,
  output logic [NUM_REQ-1:0]      r_busy,
  output logic [NUM_REQ-1:0]      r_done,
  output logic [NUM_REQ-1:0]      r_err,
  output logic [1:0]              m_rw_flag,
  output logic [31:0]             m_addr,
  output logic [31:0]             m_wdata,
  output logic [3:0]              m_wmask,
  input  logic [31:0]             m_rdata,
  input  logic                    m_busy,
  input  logic                    m_done
);

  // NUM_REQ is limited to 2..4, so a 2-bit index always suffices.
  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [IDX_W:0]   sum_t;
  typedef logic [TO_W-1:0]  cnt_t;

  localparam sum_t       C_NUM_REQ  = sum_t'(NUM_REQ);
  localparam cnt_t       C_TIMEOUT  = cnt_t'(TIMEOUT);
  localparam logic [1:0] C_RW_IDLE  = 2'b00;
  localparam logic [1:0] C_RW_READ  = 2'b01;
  localparam logic [1:0] C_RW_WRITE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  idx_t        rr_q, rr_d;
  idx_t        grant_q, grant_d;
  logic [1:0]  rw_q, rw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wmask_q, wmask_d;
  cnt_t        cnt_q, cnt_d;
  logic        abort_q, abort_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  m_rw_q, m_rw_d;
  logic        post_resp_q, post_resp_d;

  logic [1:0]  req_flag  [NUM_REQ];
  logic [31:0] req_addr  [NUM_REQ];
  logic [31:0] req_wdata [NUM_REQ];
  logic [3:0]  req_wmask [NUM_REQ];
  logic [NUM_REQ-1:0] req_vld;

  logic        pick_found;
  idx_t        pick_idx;
  sum_t        scan;
  idx_t        rr_next;
  cnt_t        cnt_inc;
  logic        timeout_hit;

  // --------------------------------------------------------------------------
  // Per-requester unpacking and status outputs
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
      assign req_flag[i]  = r_rw_flag[2*i +: 2];
      assign req_addr[i]  = r_addr[32*i +: 32];
      assign req_wdata[i] = r_wdata[32*i +: 32];
      assign req_wmask[i] = r_wmask[4*i +: 4];

      // The requester just served still shows its old request in the IDLE
      // cycle after RESP; keep it out so that request is not granted twice.
      assign req_vld[i] = ((req_flag[i] == C_RW_READ) || (req_flag[i] == C_RW_WRITE))
                          && !(post_resp_q && (grant_q == idx_t'(i)));

      assign r_done[i] = (state_q == S_RESP) && !abort_q && (grant_q == idx_t'(i));
      assign r_err[i]  = (state_q == S_RESP) &&  abort_q && (grant_q == idx_t'(i));

      // While a transaction is in flight only the owner is not busy; in IDLE
      // everybody follows the memory port's own busy.
      assign r_busy[i] = (state_q != S_IDLE) ? (grant_q != idx_t'(i)) : m_busy;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Round-robin pick: first valid requester at or after rr_q, wrapping.
  // --------------------------------------------------------------------------
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_q;
    scan       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = sum_t'(rr_q) + sum_t'(k);
      if (scan >= C_NUM_REQ) begin
        scan = scan - C_NUM_REQ;
      end
      if (!pick_found && req_vld[scan[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[IDX_W-1:0];
      end
    end
  end

  assign rr_next     = (grant_q == idx_t'(NUM_REQ - 1)) ? '0 : grant_q + idx_t'(1);

  // Counter value this WAIT cycle ends with; timeout fires when it reaches
  // TIMEOUT, i.e. after exactly TIMEOUT cycles in WAIT.
  assign cnt_inc     = (cnt_q == C_TIMEOUT) ? cnt_q : cnt_q + cnt_t'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == C_TIMEOUT);

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wmask_d     = wmask_q;
    cnt_d       = cnt_q;
    abort_d     = abort_q;
    rdata_d     = rdata_q;
    m_rw_d      = m_rw_q;
    post_resp_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        m_rw_d = C_RW_IDLE;
        if (!m_busy && pick_found) begin
          grant_d = pick_idx;
          rw_d    = req_flag[pick_idx];
          addr_d  = req_addr[pick_idx];
          wdata_d = req_wdata[pick_idx];
          wmask_d = req_wmask[pick_idx];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        m_rw_d  = rw_q;
        cnt_d   = '0;
        abort_d = 1'b0;
        rdata_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        // m_done has priority over a timeout landing in the same cycle.
        if (m_done) begin
          rdata_d = (rw_q == C_RW_READ) ? m_rdata : 32'd0;
          m_rw_d  = C_RW_IDLE;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          abort_d = 1'b1;
          m_rw_d  = C_RW_IDLE;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        // rdata is only presented during the response cycle.
        rdata_d     = '0;
        rr_d        = rr_next;
        post_resp_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      grant_q     <= '0;
      rw_q        <= C_RW_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      wmask_q     <= '0;
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      rdata_q     <= '0;
      m_rw_q      <= C_RW_IDLE;
      post_resp_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wmask_q     <= wmask_d;
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      rdata_q     <= rdata_d;
      m_rw_q      <= m_rw_d;
      post_resp_q <= post_resp_d;
    end
  end

  assign m_rw_flag = m_rw_q;
  assign m_addr    = addr_q;
  assign m_wdata   = wdata_q;
  assign m_wmask   = wmask_q;
  assign r_rdata   = rdata_q;

endmodule
`default_nettype wire
